// File: rtl/copperv_fetch.sv
// copperv_fetch: credit-limited sequential instruction fetch with a prefetch FIFO and redirect flush.
// Define COPPERV_FETCH_BYPASS_EN to forward a kept response straight to the decoder when the FIFO is empty.
module copperv_fetch #(
  parameter int bus_width = 32,
  parameter int pc_width = 32,
  parameter logic [pc_width-1:0] pc_init = '0,
  parameter int fifo_depth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 i_raddr_valid,
  input  logic                 i_raddr_ready,
  output logic [bus_width-1:0] i_raddr,
  input  logic                 i_rdata_valid,
  output logic                 i_rdata_ready,
  input  logic [bus_width-1:0] i_rdata,
  input  logic                 redirect_valid,
  input  logic [pc_width-1:0]  redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [bus_width-1:0] inst,
  output logic [pc_width-1:0]  inst_pc
);
  localparam int aw = $clog2(fifo_depth);
  localparam int cw = aw + 1;
  localparam logic [cw:0] depth_l = (cw+1)'(fifo_depth);
  logic [pc_width-1:0] fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d, resp_pc_q, resp_pc_d, rpc, issue_pc;
  logic req_valid_q, req_valid_d;
  logic [cw-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d, cnt_eff;
  logic [aw-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [pc_width+bus_width-1:0] mem_q [fifo_depth];
  logic hs, credit, issue, kept, push, pop, byp, empty;
  assign hs = req_valid_q & i_raddr_ready;
  assign rpc = redirect_pc & ~pc_width'(3);
  assign empty = (cnt_q == '0);
  assign kept = i_rdata_valid & ~redirect_valid & (disc_q == '0);
`ifdef COPPERV_FETCH_BYPASS_EN
  assign byp = empty & kept;
`else
  assign byp = 1'b0;
`endif
  assign inst_valid = ~redirect_valid & (~empty | byp);
  assign {inst_pc, inst} = byp ? {resp_pc_q, i_rdata} : mem_q[rd_q];
  assign pop = ~empty & inst_ready & ~redirect_valid;
  assign push = kept & ~(byp & inst_ready);
  // a redirect flushes the FIFO, so its entries no longer hold back credit
  assign cnt_eff = redirect_valid ? '0 : cnt_q;
  assign credit = ({1'b0, cnt_eff} + {1'b0, out_q} + (cw+1)'(req_valid_q)) < depth_l;
  assign issue = credit & (~req_valid_q | hs);
  assign issue_pc = redirect_valid ? rpc : fetch_pc_q;
  assign i_raddr_valid = req_valid_q;
  assign i_raddr = bus_width'(req_addr_q);
  assign i_rdata_ready = 1'b1;
  always_comb begin
    req_valid_d = issue | (req_valid_q & ~hs);
    req_addr_d = issue ? issue_pc : req_addr_q;
    fetch_pc_d = issue ? issue_pc + pc_width'(4) : issue_pc;
    resp_pc_d = redirect_valid ? rpc : (kept ? resp_pc_q + pc_width'(4) : resp_pc_q);
    out_d = out_q + cw'(hs) - cw'(i_rdata_valid);
    disc_d = redirect_valid ? out_q + cw'(req_valid_q) - cw'(i_rdata_valid)
                            : disc_q - cw'(i_rdata_valid & (disc_q != '0));
    cnt_d = redirect_valid ? '0 : cnt_q + cw'(push) - cw'(pop);
    rd_d = redirect_valid ? '0 : rd_q + aw'(pop);
    wr_d = redirect_valid ? '0 : wr_q + aw'(push);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= pc_init;
      req_valid_q <= 1'b0;
      req_addr_q <= pc_init;
      resp_pc_q <= pc_init;
      out_q <= '0;
      disc_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      for (int i = 0; i < fifo_depth; i++) mem_q[i] <= {pc_init, {bus_width{1'b0}}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q <= req_addr_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      disc_q <= disc_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      if (push) mem_q[wr_q] <= {resp_pc_q, i_rdata};
    end
  end
endmodule
